// File: rtl/fabric32_pkg.sv
// Shared types and constants for the fabric32 shortest-path engine.
package fabric32_pkg;

    localparam int NODES      = 32;
    localparam int NODE_W     = 5;
    localparam int MAX_EDGES  = 128;
    localparam int MAX_PASSES = 31;

    localparam logic [31:0] RD_BASE     = 32'h0400_0000;
    localparam logic [31:0] WR_BASE     = 32'h0400_2000;
    localparam logic [15:0] INF         = 16'hFFFF;
    localparam logic [7:0]  MAX_EDGES_L = 8'd128;
    localparam logic [7:0]  MAX_PASS_L  = 8'd31;

    // Control word field positions
    localparam int CTRL_START   = 0;
    localparam int CTRL_INT_CLR = 1;
    localparam int CTRL_SRC_LSB = 4;
    localparam int CTRL_CNT_LSB = 16;

    // Edge word field positions
    localparam int EDGE_SRC_LSB = 0;
    localparam int EDGE_DST_LSB = 5;
    localparam int EDGE_W_LSB   = 10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RD_REQ   = 4'd1,
        S_RD_WAIT  = 4'd2,
        S_RELAX    = 4'd3,
        S_PASS_END = 4'd4,
        S_WR_REQ   = 4'd5,
        S_WR_WAIT  = 4'd6,
        S_DONE     = 4'd7
    } state_t;

    function automatic logic [4:0] edge_src(input logic [31:0] word);
        return word[EDGE_SRC_LSB +: 5];
    endfunction

    function automatic logic [4:0] edge_dst(input logic [31:0] word);
        return word[EDGE_DST_LSB +: 5];
    endfunction

    function automatic logic [15:0] edge_weight(input logic [31:0] word);
        return word[EDGE_W_LSB +: 16];
    endfunction

    // Requested edge counts above the table size are limited to the table size
    function automatic logic [7:0] clamp_count(input logic [7:0] cnt);
        if (cnt > MAX_EDGES_L) begin
            return MAX_EDGES_L;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/fabric32_relax.sv
// Single-edge relaxation: saturating distance add and improvement test.
module fabric32_relax
    import fabric32_pkg::*;
(
    input  logic [4:0]  i_src,
    input  logic [4:0]  i_dst,
    input  logic [15:0] i_dist_src,
    input  logic [15:0] i_dist_dst,
    input  logic [15:0] i_weight,
    output logic [15:0] o_new_dist,
    output logic        o_update
);

    logic [16:0] w_sum_full;
    logic [15:0] w_sum_sat;

    assign w_sum_full = {1'b0, i_dist_src} + {1'b0, i_weight};

    // Clamp the candidate at INF so an overflowing path never looks shorter
    always_comb begin
        w_sum_sat = INF;
        if (w_sum_full[16]) begin
            w_sum_sat = INF;
        end else begin
            w_sum_sat = w_sum_full[15:0];
        end
    end

    // Unreachable sources and self-loops never improve anything
    always_comb begin
        o_update = 1'b0;
        if ((i_dist_src != INF) && (i_src != i_dst) && (w_sum_sat < i_dist_dst)) begin
            o_update = 1'b1;
        end else begin
            o_update = 1'b0;
        end
    end

    assign o_new_dist = w_sum_sat;

endmodule

// File: rtl/fabric32.sv
// Bellman-Ford engine: fetches an edge list, relaxes until stable, writes distances.
module fabric32
    import fabric32_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        ctrl_wr,
    input  logic [31:0] ctrl_in,
    output logic [31:0] ctrl_out,
    output logic        req_rd,
    output logic        req_wr,
    output logic [31:0] addr_rd,
    output logic [31:0] addr_wr,
    output logic [31:0] data_wr,
    input  logic [31:0] data_rd,
    input  logic        data_rdy,
    output logic        int_done
);

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_int_done;
    logic [7:0]  r_pass;
    logic [7:0]  r_count;
    logic [6:0]  r_edge_idx;
    logic [4:0]  r_node_idx;
    logic        r_changed;
    logic [1:0]  r_blank_cnt;
    logic [31:0] r_edge;
    logic        r_req_rd;
    logic        r_req_wr;
    logic [31:0] r_addr_rd;
    logic [31:0] r_addr_wr;
    logic [31:0] r_data_wr;
    logic [15:0] r_dist [0:NODES-1];

    logic [4:0]  w_start_src;
    logic [7:0]  w_start_cnt;
    logic [4:0]  w_edge_src;
    logic [4:0]  w_edge_dst;
    logic [15:0] w_edge_weight;
    logic [15:0] w_new_dist;
    logic        w_update;
    logic [7:0]  w_next_edge;
    logic [7:0]  w_next_pass;
    logic        w_unused;

    assign w_start_src   = ctrl_in[CTRL_SRC_LSB +: NODE_W];
    assign w_start_cnt   = clamp_count(ctrl_in[CTRL_CNT_LSB +: 8]);
    assign w_edge_src    = edge_src(r_edge);
    assign w_edge_dst    = edge_dst(r_edge);
    assign w_edge_weight = edge_weight(r_edge);
    assign w_next_edge   = {1'b0, r_edge_idx} + 8'd1;
    assign w_next_pass   = r_pass + 8'd1;

    // Control and edge-word bits that carry no meaning for this block
    assign w_unused = ^{ctrl_in[31:24], ctrl_in[15:9], ctrl_in[3:2], r_edge[31:26]};

    fabric32_relax u_relax (
        .i_src      (w_edge_src),
        .i_dst      (w_edge_dst),
        .i_dist_src (r_dist[w_edge_src]),
        .i_dist_dst (r_dist[w_edge_dst]),
        .i_weight   (w_edge_weight),
        .o_new_dist (w_new_dist),
        .o_update   (w_update)
    );

    // Main controller: host control, memory handshake, relaxation passes, write-back
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_int_done  <= 1'b0;
            r_pass      <= 8'd0;
            r_count     <= 8'd0;
            r_edge_idx  <= 7'd0;
            r_node_idx  <= 5'd0;
            r_changed   <= 1'b0;
            r_blank_cnt <= 2'd0;
            r_edge      <= 32'd0;
            r_req_rd    <= 1'b0;
            r_req_wr    <= 1'b0;
            r_addr_rd   <= 32'd0;
            r_addr_wr   <= 32'd0;
            r_data_wr   <= 32'd0;
            for (int n = 0; n < NODES; n++) begin
                r_dist[n] <= INF;
            end
        end else begin
            // Request strobes are single-cycle pulses unless re-asserted below
            r_req_rd <= 1'b0;
            r_req_wr <= 1'b0;

            // Interrupt clear is honoured in every state, busy or not
            if (ctrl_wr && ctrl_in[CTRL_INT_CLR]) begin
                r_done     <= 1'b0;
                r_int_done <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (ctrl_wr && ctrl_in[CTRL_START]) begin
                        r_done     <= 1'b0;
                        r_int_done <= 1'b0;
                        r_busy     <= 1'b1;
                        r_pass     <= 8'd0;
                        r_count    <= w_start_cnt;
                        r_edge_idx <= 7'd0;
                        r_node_idx <= 5'd0;
                        r_changed  <= 1'b0;
                        for (int n = 0; n < NODES; n++) begin
                            r_dist[n] <= (5'(n) == w_start_src) ? 16'h0000 : INF;
                        end
                        // An empty edge list goes straight to write-back
                        if (w_start_cnt == 8'd0) begin
                            r_state <= S_WR_REQ;
                        end else begin
                            r_state <= S_RD_REQ;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RD_REQ: begin
                    if (data_rdy) begin
                        r_req_rd    <= 1'b1;
                        r_addr_rd   <= RD_BASE + {23'd0, r_edge_idx, 2'b00};
                        r_blank_cnt <= 2'd2;
                        r_state     <= S_RD_WAIT;
                    end else begin
                        r_state <= S_RD_REQ;
                    end
                end

                S_RD_WAIT: begin
                    // Ignore ready during the request cycle and the one after it
                    if (r_blank_cnt != 2'd0) begin
                        r_blank_cnt <= r_blank_cnt - 2'd1;
                    end else if (data_rdy) begin
                        r_edge  <= data_rd;
                        r_state <= S_RELAX;
                    end else begin
                        r_state <= S_RD_WAIT;
                    end
                end

                S_RELAX: begin
                    if (w_update) begin
                        r_dist[w_edge_dst] <= w_new_dist;
                        r_changed          <= 1'b1;
                    end
                    if (w_next_edge < r_count) begin
                        r_edge_idx <= w_next_edge[6:0];
                        r_state    <= S_RD_REQ;
                    end else begin
                        r_state <= S_PASS_END;
                    end
                end

                S_PASS_END: begin
                    r_pass <= w_next_pass;
                    // Another pass only if something moved and the pass budget allows it
                    if (r_changed && (w_next_pass < MAX_PASS_L)) begin
                        r_edge_idx <= 7'd0;
                        r_changed  <= 1'b0;
                        r_state    <= S_RD_REQ;
                    end else begin
                        r_node_idx <= 5'd0;
                        r_state    <= S_WR_REQ;
                    end
                end

                S_WR_REQ: begin
                    if (data_rdy) begin
                        r_req_wr    <= 1'b1;
                        r_addr_wr   <= WR_BASE + {25'd0, r_node_idx, 2'b00};
                        r_data_wr   <= {16'h0000, r_dist[r_node_idx]};
                        r_blank_cnt <= 2'd2;
                        r_state     <= S_WR_WAIT;
                    end else begin
                        r_state <= S_WR_REQ;
                    end
                end

                S_WR_WAIT: begin
                    if (r_blank_cnt != 2'd0) begin
                        r_blank_cnt <= r_blank_cnt - 2'd1;
                    end else if (data_rdy) begin
                        if (r_node_idx == 5'(NODES - 1)) begin
                            // Flags change together so they are visible in the DONE cycle
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_int_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_node_idx <= r_node_idx + 5'd1;
                            r_state    <= S_WR_REQ;
                        end
                    end else begin
                        r_state <= S_WR_WAIT;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_out = {16'h0000, r_pass, 6'b000000, r_done, r_busy};
    assign int_done = r_int_done;
    assign req_rd   = r_req_rd;
    assign req_wr   = r_req_wr;
    assign addr_rd  = r_addr_rd;
    assign addr_wr  = r_addr_wr;
    assign data_wr  = r_data_wr;

endmodule

// File: tb/tb_fabric32.sv
// Self-checking bench for fabric32: randomized graphs against a shortest-path reference.
module tb_fabric32;

    localparam logic [31:0] RD_BASE = 32'h0400_0000;
    localparam logic [31:0] WR_BASE = 32'h0400_2000;
    localparam int          INF     = 65535;

    logic        clk;
    logic        arst_n;
    logic        ctrl_wr;
    logic [31:0] ctrl_in;
    logic [31:0] ctrl_out;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] addr_rd;
    logic [31:0] addr_wr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        data_rdy;
    logic        int_done;

    fabric32 dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .ctrl_wr  (ctrl_wr),
        .ctrl_in  (ctrl_in),
        .ctrl_out (ctrl_out),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .addr_rd  (addr_rd),
        .addr_wr  (addr_wr),
        .data_wr  (data_wr),
        .data_rd  (data_rd),
        .data_rdy (data_rdy),
        .int_done (int_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image and observation state
    logic [31:0] mem [0:127];
    logic [15:0] wr_data [0:31];
    int          exp_dist [0:31];
    int          rd_total  = 0;
    int          wr_total  = 0;
    int          proto_err = 0;
    int          addr_err  = 0;
    int          max_dly   = 0;
    int          busy_cnt  = 0;
    int          dly_s     = 0;
    logic [31:0] off_s;
    int          checks    = 0;
    int          errors    = 0;

    // Memory responder: busy for a random number of cycles after each request
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_rdy <= 1'b1;
            busy_cnt <= 0;
            data_rd  <= 32'd0;
        end else if (req_rd || req_wr) begin
            dly_s = $urandom_range(max_dly, 0);
            if (dly_s == 0) begin
                data_rdy <= 1'b1;
            end else begin
                data_rdy <= 1'b0;
                busy_cnt <= dly_s;
            end
            if (req_rd) begin
                off_s = addr_rd - RD_BASE;
                if (off_s < 32'd512) data_rd <= mem[off_s[8:2]];
                else                 data_rd <= 32'hDEAD_BEEF;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) data_rdy <= 1'b1;
        end
    end

    // Bus monitor: counts traffic, captures write-back, flags protocol breaches
    always @(posedge clk) begin
        if ((req_rd || req_wr) && !data_rdy) proto_err <= proto_err + 1;
        if (req_rd && req_wr)                proto_err <= proto_err + 1;
        if (req_rd) begin
            rd_total <= rd_total + 1;
            if ((addr_rd[1:0] != 2'b00) || (addr_rd < RD_BASE) || (addr_rd >= RD_BASE + 32'd512))
                addr_err <= addr_err + 1;
        end
        if (req_wr) begin
            wr_total <= wr_total + 1;
            wr_data[wr_total[4:0]] <= data_wr[15:0];
            if ((addr_wr != WR_BASE + 32'(4 * (wr_total % 32))) || (data_wr[31:16] != 16'h0000))
                addr_err <= addr_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_edge(input int s, input int d, input int w);
        logic [31:0] r;
        r = {6'h00, 16'(w), 5'(d), 5'(s)};
        return r;
    endfunction

    // Reference: repeated in-order relaxation over the list until stable, at most 31 passes
    task automatic ref_model(input int s, input int cnt, output int passes);
        int  eff, u, v, w, sum;
        bit  changed;
        eff = (cnt > 128) ? 128 : cnt;
        for (int n = 0; n < 32; n++) exp_dist[n] = (n == s) ? 0 : INF;
        passes = 0;
        if (eff > 0) begin
            do begin
                changed = 1'b0;
                for (int e = 0; e < eff; e++) begin
                    u = int'(mem[e][4:0]);
                    v = int'(mem[e][9:5]);
                    w = int'(mem[e][25:10]);
                    if (exp_dist[u] != INF && u != v) begin
                        sum = exp_dist[u] + w;
                        if (sum > INF) sum = INF;
                        if (sum < exp_dist[v]) begin
                            exp_dist[v] = sum;
                            changed = 1'b1;
                        end
                    end
                end
                passes++;
            end while (changed && passes < 31);
        end
    endtask

    task automatic start_cmd(input int src, input int cnt);
        @(posedge clk); #1;
        ctrl_wr = 1'b1;
        ctrl_in = {8'h00, 8'(cnt), 7'h00, 5'(src), 4'b0001};
        @(posedge clk); #1;
        ctrl_wr = 1'b0;
        ctrl_in = 32'd0;
    endtask

    task automatic run_graph(input string tag, input int src, input int cnt, input bit poke);
        int passes, eff, base_rd, base_wr;
        bit got;
        ref_model(src, cnt, passes);
        eff = (cnt > 128) ? 128 : cnt;
        base_rd = rd_total;
        base_wr = wr_total;
        start_cmd(src, cnt);
        check({tag, "_busy"}, ctrl_out, 32'h0000_0001);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            ctrl_wr = 1'b1;
            ctrl_in = {8'h00, 8'd1, 7'h00, 5'd31, 4'b0001};
            @(posedge clk); #1;
            ctrl_wr = 1'b0;
            ctrl_in = 32'd0;
            check({tag, "_still_busy"}, {31'd0, ctrl_out[0]}, 32'd1);
        end
        got = 1'b0;
        for (int c = 0; c < 40000 && !got; c++) begin
            @(posedge clk); #1;
            if (int_done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_ctrl_out"}, ctrl_out, {16'h0000, 8'(passes), 6'h00, 2'b10});
            check({tag, "_reads"}, 32'(rd_total - base_rd), 32'(passes * eff));
            check({tag, "_writes"}, 32'(wr_total - base_wr), 32'd32);
            for (int n = 0; n < 32; n++)
                check($sformatf("%s_dist%0d", tag, n), {16'h0000, wr_data[n]}, 32'(exp_dist[n]));
            check({tag, "_proto"}, 32'(proto_err), 32'd0);
            check({tag, "_addr"}, 32'(addr_err), 32'd0);
        end
    endtask

    task automatic fill_random(input int cnt, input int span);
        int s, d, w;
        for (int e = 0; e < 128; e++) begin
            s = $urandom_range(span - 1, 0);
            d = $urandom_range(span + 1, 0);
            w = ($urandom_range(9, 0) == 0) ? 65535 : $urandom_range(60, 0);
            mem[e] = mk_edge(s, d, w) | {6'($urandom_range(63, 0)), 26'd0};
        end
        if (cnt > 128) cnt = 128;
    endtask

    initial begin
        arst_n  = 1'b0;
        ctrl_wr = 1'b0;
        ctrl_in = 32'd0;
        for (int e = 0; e < 128; e++) mem[e] = 32'd0;
        #7;
        check("rst_ctrl_out", ctrl_out, 32'd0);
        check("rst_int_done", {31'd0, int_done}, 32'd0);
        check("rst_req", {30'd0, req_rd, req_wr}, 32'd0);
        check("rst_addr_rd", addr_rd, 32'd0);
        check("rst_data_wr", data_wr, 32'd0);
        #20;
        arst_n = 1'b1;

        // Single edge 0->1 w5
        mem[0] = mk_edge(0, 1, 5);
        run_graph("single", 0, 1, 1'b0);
        check("single_ctrl_lit", ctrl_out, 32'h0000_0202);
        check("single_d1_lit", {16'h0, wr_data[1]}, 32'h0000_0005);

        // Done holds until cleared, then falls the cycle after int_clr
        repeat (5) @(posedge clk);
        #1;
        check("done_hold", {31'd0, int_done}, 32'd1);
        ctrl_wr = 1'b1;
        ctrl_in = 32'h0000_0002;
        @(posedge clk); #1;
        ctrl_wr = 1'b0;
        ctrl_in = 32'd0;
        check("clr_int_done", {31'd0, int_done}, 32'd0);
        check("clr_done_bit", {30'd0, ctrl_out[1:0]}, 32'd0);

        // Reverse-ordered chain
        mem[0] = mk_edge(2, 3, 3);
        mem[1] = mk_edge(1, 2, 2);
        mem[2] = mk_edge(0, 1, 1);
        run_graph("chain", 0, 3, 1'b0);
        check("chain_ctrl_lit", ctrl_out, 32'h0000_0402);
        check("chain_d3_lit", {16'h0, wr_data[3]}, 32'd6);

        // Empty edge list
        run_graph("empty", 7, 0, 1'b0);
        check("empty_d7_lit", {16'h0, wr_data[7]}, 32'd0);

        // Saturation: INF + w stays INF, and unreachable sources are skipped
        mem[0] = mk_edge(0, 1, 1);
        mem[1] = mk_edge(1, 2, 65535);
        mem[2] = mk_edge(2, 3, 0);
        run_graph("sat", 0, 3, 1'b0);
        check("sat_d2_lit", {16'h0, wr_data[2]}, 32'h0000_FFFF);

        // Long reverse chain hits the 31-pass cap
        for (int e = 0; e < 31; e++) mem[e] = mk_edge(30 - e, 31 - e, 2);
        run_graph("cap31", 0, 31, 1'b0);
        check("cap31_ctrl_lit", ctrl_out, 32'h0000_1F02);

        // Same single edge under random ready delays
        max_dly = 5;
        mem[0] = mk_edge(0, 1, 5);
        run_graph("single_dly", 0, 1, 1'b0);

        // Randomized graphs with random memory latency; first one pokes start while busy
        for (int t = 0; t < 5; t++) begin
            int cnt;
            cnt = $urandom_range(24, 4);
            fill_random(cnt, 8);
            run_graph($sformatf("rand%0d", t), $urandom_range(3, 0), cnt, (t == 0));
        end

        // Edge count above the table size is clamped
        max_dly = 1;
        fill_random(128, 10);
        run_graph("clamp", 0, 200, 1'b0);

        // Reset in the middle of a read phase aborts all traffic
        begin
            int base_rd, base_wr;
            max_dly = 2;
            fill_random(20, 8);
            start_cmd(0, 20);
            repeat (25) @(posedge clk);
            #3;
            arst_n = 1'b0;
            #1;
            check("mid_rst_ctrl_out", ctrl_out, 32'd0);
            check("mid_rst_int_done", {31'd0, int_done}, 32'd0);
            check("mid_rst_req", {30'd0, req_rd, req_wr}, 32'd0);
            check("mid_rst_addr_rd", addr_rd, 32'd0);
            check("mid_rst_addr_wr", addr_wr, 32'd0);
            check("mid_rst_data_wr", data_wr, 32'd0);
            base_rd = rd_total;
            base_wr = wr_total;
            repeat (3) @(posedge clk);
            #1;
            arst_n = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            check("mid_rst_no_reads", 32'(rd_total - base_rd), 32'd0);
            check("mid_rst_no_writes", 32'(wr_total - base_wr), 32'd0);
            check("mid_rst_idle", ctrl_out, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fabric32.md
Name: fabric32

Overview:
- Single-source shortest-path engine ("Bellman-Ford fabric") for graphs of up to 32 nodes with unsigned 16-bit edge weights.
- Host programs a 32-bit control word; the block fetches a packed edge list from memory through a simple request/ready port.
- It relaxes all edges repeatedly until no distance changes (at most 31 passes), then writes 32 distance words back to memory and raises int_done.

Parameters:
- RD_BASE, 32'h0400_0000, byte address of edge list (word i at RD_BASE+4*i)
- WR_BASE, 32'h0400_2000, byte address of result (distance of node n at WR_BASE+4*n)
- NODES, 32, node count (fixed; node ids 5 bits)
- MAX_EDGES, 128, edge-count clamp

Ports:
- clk  in  1  system clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- ctrl_wr  in  1  write strobe for ctrl_in, one cycle
- ctrl_in  in  32  [0] start, [1] int_clr, [8:4] source node, [23:16] edge count
- ctrl_out  out  32  [0] busy, [1] done, [15:8] passes executed, others 0
- req_rd  out  1  read request pulse
- req_wr  out  1  write request pulse
- addr_rd  out  32  read byte address
- addr_wr  out  32  write byte address
- data_wr  out  32  write data
- data_rd  in  32  read data
- data_rdy  in  1  memory idle/ready; also read-data-valid after a read
- int_done  out  1  level interrupt, equals done flag

Behaviour:
- Reset (async): all outputs 0; state IDLE; busy=done=0; pass count 0; dist[0..31]=16'hFFFF (INF).
- Control write: ctrl_wr with int_clr=1 clears done. Start=1 in IDLE: clears done, latches source and count (clamped to MAX_EDGES), sets dist[src]=0, all others INF, busy=1. Start while busy ignored (int_clr still honoured).
- Edge word: [4:0] src, [9:5] dst, [25:10] weight; other bits ignored.
- States: IDLE -> RD_REQ -> RD_WAIT -> RELAX -> (next edge RD_REQ | PASS_END) ; PASS_END -> RD_REQ (new pass) or WR_REQ ; WR_REQ -> WR_WAIT -> (next node WR_REQ | DONE) ; DONE -> IDLE.
- Memory handshake: a request (req_rd or req_wr high exactly one cycle, addresses/data valid that cycle) is issued only in a cycle where data_rdy=1. Cycle after a request, data_rdy is ignored (blanking). Thereafter the block waits for data_rdy=1; for reads, data_rd is captured on that edge. req_rd and req_wr never both high. Addresses/data hold their value until the next request.
- RELAX: if dist[src]!=INF and src!=dst, sum=dist[src]+weight saturating at 16'hFFFF; if sum<dist[dst], dist[dst]=sum and pass-changed flag set. Single cycle.
- PASS_END: pass count++; new pass if changed and pass count<31, else write phase.
- Edge count 0: skip directly to write phase, pass count 0.
- Write phase: node 0..31 in order, data_wr={16'h0,dist[n]}, addr_wr=WR_BASE+4n.
- DONE: busy=0, done=1, int_done=1 same cycle; done holds until int_clr or new start.
- ctrl_out updates combinationally from registers; int_done registered.
- Reset mid-operation aborts immediately; no further requests issued.

Decomposition:
- Package fabric32_pkg: state enum, RD_BASE/WR_BASE, INF constant, ctrl bit-field positions, edge-word field positions.
- One sub-module natural: fabric32_relax (combinational saturating add + compare, outputs new distance and update flag).
- Distance file as 32x16 register array inside top.

Test Plan:
- Reset: assert arst_n=0 mid-clock -> all outputs 0 immediately, ctrl_out=0, int_done=0.
- Single edge {src=0,dst=1,w=5}, source 0, count 1 -> 2 passes, writes 0x0 at 0x04002000, 0x5 at 0x04002004, 0xFFFF at others; ctrl_out=0x0000_0202 (done, passes 2), int_done=1.
- Reverse-ordered chain edges 2->3 w3, 1->2 w2, 0->1 w1, source 0 -> dist {0,1,3,6,INF...}; 4 passes.
- Count 0, source 7 -> no reads, node 7 writes 0, all others 0xFFFF; passes 0.
- Memory with variable data_rdy delay (0..5 cycles) -> no request issued while data_rdy=0, identical results.
- Start while busy ignored; after done, ctrl_wr int_clr=1 -> int_done and done fall next cycle; saturation edge w=0xFFFF from dist 1 leaves target INF.
